// File: rtl/jk_counter_bank_pkg.sv
// jk_counter_bank_pkg: shared mode encoding and default bank width.
package jk_counter_bank_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/jk_counter_bank_cell.sv
// jk_cell: one falling-edge JK flip-flop with async active-low reset and
// synchronous set / clear / invert (set and clear together invert the cell).
module jk_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic i_set,
  input  logic i_clr,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  // Cell state: reset, then set/clr/invert overrides, then JK behaviour.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= 1'b0;
    end else if (i_set && i_clr) begin
      r_q <= ~r_q;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end else if (i_set) begin
      r_q <= 1'b1;
    end else begin
      case ({i_j, i_k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jk_counter_bank.sv
// jk_counter_bank: WIDTH-bit bank of JK cells usable as independent JK
// flip-flops or as a synchronous up/down counter, with a registered
// terminal-count flag. All state changes on the falling edge of clk.
// Optional build macro: JK_COUNTER_BANK_SATURATE_EN (counter holds at the
// end of range instead of wrapping; tc flags every blocked step).
module jk_counter_bank
  import jk_counter_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  mode_e            w_mode;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH:0]   w_all1;   // w_all1[i]: bits below i are all ones
  logic [WIDTH:0]   w_all0;   // w_all0[i]: bits below i are all zeros
  logic             w_at_max;
  logic             w_at_min;
  logic             w_up_block;
  logic             w_dn_block;
  logic             r_tc;

  assign w_mode = mode_e'(mode);

  assign w_all1[0] = 1'b1;
  assign w_all0[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_cell
      assign w_all1[g+1] = w_all1[g] & w_q[g];
      assign w_all0[g+1] = w_all0[g] & ~w_q[g];

      jk_cell u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .i_set   (set),
        .i_clr   (clr),
        .i_j     (w_j[g]),
        .i_k     (w_k[g]),
        .o_q     (w_q[g])
      );
    end
  endgenerate

  assign w_at_max = w_all1[WIDTH];
  assign w_at_min = w_all0[WIDTH];

`ifdef JK_COUNTER_BANK_SATURATE_EN
  assign w_up_block = w_at_max;
  assign w_dn_block = w_at_min;
`else
  assign w_up_block = 1'b0;
  assign w_dn_block = 1'b0;
`endif

  // Per-cell J/K: direct inputs in JK mode, lower-bit toggle chain when counting.
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (en) begin
      case (w_mode)
        MODE_JK: begin
          w_j = j;
          w_k = k;
        end
        MODE_UP: begin
          if (!w_up_block) begin
            w_j = w_all1[WIDTH-1:0];
            w_k = w_all1[WIDTH-1:0];
          end
        end
        MODE_DOWN: begin
          if (!w_dn_block) begin
            w_j = w_all0[WIDTH-1:0];
            w_k = w_all0[WIDTH-1:0];
          end
        end
        default: begin
          w_j = '0;
          w_k = '0;
        end
      endcase
    end
  end

  // Terminal count: flags a step taken from the end of the counting range
  // (a wrap, or a blocked step in the saturating build); holds when idle.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tc <= 1'b0;
    end else if (set || clr) begin
      r_tc <= 1'b0;
    end else if (en) begin
      case (w_mode)
        MODE_JK:   r_tc <= 1'b0;
        MODE_UP:   r_tc <= w_at_max;
        MODE_DOWN: r_tc <= w_at_min;
        default:   r_tc <= r_tc;
      endcase
    end
  end

  assign q  = w_q;
  assign tc = r_tc;

endmodule

// File: tb/tb_jk_counter_bank.sv
// tb_jk_counter_bank: directed scoreboard bench for jk_counter_bank, WIDTH=4.
module tb_jk_counter_bank;

  localparam int W = 4;
  localparam logic [1:0] M_JK = 2'd0, M_UP = 2'd1, M_DN = 2'd2, M_HOLD = 2'd3;

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         set, clr, en;
  logic [1:0]   mode;
  logic [W-1:0] j, k;
  logic [W-1:0] q;
  logic         tc;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  jk_counter_bank #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .set     (set),
    .clr     (clr),
    .en      (en),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .q       (q),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] exp_q, input logic exp_tc);
    n_total++;
    assert (q === exp_q) n_pass++;
    else $error("FAIL %s q: got %h expected %h", tag, q, exp_q);
    n_total++;
    assert (tc === exp_tc) n_pass++;
    else $error("FAIL %s tc: got %b expected %b", tag, tc, exp_tc);
  endtask

  // Drive one set of inputs, push the expectation, compare after the falling edge.
  task automatic step(input string tag, input logic s, input logic c, input logic e,
                      input logic [1:0] m, input logic [W-1:0] jj, input logic [W-1:0] kk,
                      input logic [W-1:0] exp_q, input logic exp_tc);
    exp_t x;
    @(posedge clk);
    set = s; clr = c; en = e; mode = m; j = jj; k = kk;
    x.q = exp_q; x.tc = exp_tc;
    sb.push_back(x);
    @(negedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      x = sb.pop_front();
      check(tag, x.q, x.tc);
    end
  endtask

  task automatic load(input string tag, input logic [W-1:0] v);
    step(tag, 1'b0, 1'b0, 1'b1, M_JK, v, ~v, v, 1'b0);
  endtask

  // Async reset between edges: q/tc must clear without a clock edge.
  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check(tag, '0, 1'b0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic sat;
`ifdef JK_COUNTER_BANK_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    reset_n = 1'b0; set = 0; clr = 0; en = 0; mode = M_HOLD; j = '0; k = '0;
    #2;
    check("reset_init", '0, 1'b0);
    #1;
    reset_n = 1'b1;

    // Reset from a loaded value
    load("load_a", 4'hA);
    pulse_reset("reset_from_a");

    // JK mode
    step("jk_set_clr", 0, 0, 1, M_JK, 4'b1010, 4'b0101, 4'b1010, 1'b0);
    step("jk_toggle",  0, 0, 1, M_JK, 4'b1111, 4'b1111, 4'b0101, 1'b0);
    step("jk_hold",    0, 0, 1, M_JK, 4'b0000, 4'b0000, 4'b0101, 1'b0);

    // UP wrap / saturate
    load("load_e", 4'hE);
    step("up_1", 0, 0, 1, M_UP, '0, '0, 4'hF, 1'b0);
    step("up_2", 0, 0, 1, M_UP, '0, '0, sat ? 4'hF : 4'h0, 1'b1);
    step("up_3", 0, 0, 1, M_UP, '0, '0, sat ? 4'hF : 4'h1, sat);

    // DOWN wrap / saturate
    load("load_1", 4'h1);
    step("dn_1", 0, 0, 1, M_DN, '0, '0, 4'h0, 1'b0);
    step("dn_2", 0, 0, 1, M_DN, '0, '0, sat ? 4'h0 : 4'hF, 1'b1);
    step("dn_3", 0, 0, 1, M_DN, '0, '0, sat ? 4'h0 : 4'hE, sat);

    // Reset while tc is high
    step("clr_before", 0, 1, 0, M_DN, '0, '0, 4'h0, 1'b0);
    step("dn_wrap_tc", 0, 0, 1, M_DN, '0, '0, sat ? 4'h0 : 4'hF, 1'b1);
    pulse_reset("reset_tc_high");

    // Priority
    load("load_6", 4'h6);
    step("invert",    1, 1, 1, M_UP, '0, '0, 4'h9, 1'b0);
    step("clr_en0",   0, 1, 0, M_UP, '0, '0, 4'h0, 1'b0);
    step("dn_tc",     0, 0, 1, M_DN, '0, '0, sat ? 4'h0 : 4'hF, 1'b1);
    step("set_in_up", 1, 0, 1, M_UP, '0, '0, 4'hF, 1'b0);
    step("set_jk_ovr", 1, 0, 1, M_JK, 4'h0, 4'hF, 4'hF, 1'b0);

    // Enable / HOLD with tc low
    load("load_3", 4'h3);
    for (int i = 0; i < 3; i++) step("en0_hold", 0, 0, 0, M_UP, '0, '0, 4'h3, 1'b0);
    for (int i = 0; i < 2; i++) step("mode_hold", 0, 0, 1, M_HOLD, '0, '0, 4'h3, 1'b0);
    step("resume_dn", 0, 0, 1, M_DN, '0, '0, 4'h2, 1'b0);

    // Enable / HOLD with tc high
    step("set_f", 1, 0, 1, M_HOLD, '0, '0, 4'hF, 1'b0);
    step("up_wrap", 0, 0, 1, M_UP, '0, '0, sat ? 4'hF : 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) step("en0_tc1", 0, 0, 0, M_DN, '0, '0, sat ? 4'hF : 4'h0, 1'b1);
    for (int i = 0; i < 2; i++) step("hold_tc1", 0, 0, 1, M_HOLD, '0, '0, sat ? 4'hF : 4'h0, 1'b1);
    step("up_after", 0, 0, 1, M_UP, '0, '0, sat ? 4'hF : 4'h1, sat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
